// File: rtl/mapper_ascii_gen.sv
// ASCII-family MegaROM mapper (8 KB or 16 KB banks) with registered memory-side outputs.
// Optional SRAM banking is compiled in with `define MAPPER_GEN_SRAM_EN.
module mapper_ascii_gen #(
  parameter int unsigned BANK_BITS  = 13,
  parameter int unsigned BANK_REG_W = 8,
  parameter int unsigned SRAM_BIT   = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic                    mreq,
  input  logic                    rd,
  input  logic                    wr,
  input  logic [15:0]             addr,
  input  logic [7:0]              data,
  input  logic [24:0]             rom_size,
  input  logic [26:0]             base_ram,
  input  logic [15:0]             sram_size,
  input  logic [26:0]             sram_base,
  output logic [26:0]             out_addr,
  output logic                    out_ram_cs,
  output logic                    out_sram_cs,
  output logic                    out_rnw,
  output logic [4*BANK_REG_W-1:0] bank_dbg
);

  localparam int unsigned NUM_WIN = 32'h8000 >> BANK_BITS;

  generate
    if (BANK_BITS != 13 && BANK_BITS != 14) begin : g_bad_bank_bits
      $error("mapper_ascii_gen: BANK_BITS must be 13 or 14");
    end
    if (SRAM_BIT >= BANK_REG_W) begin : g_bad_sram_bit
      $error("mapper_ascii_gen: SRAM_BIT must lie inside the bank register");
    end
  endgenerate

  logic [BANK_REG_W-1:0] bank_q [4];
  logic                  prev_wr_q;
  logic                  post_reset_q;

  logic                  wr_req;
  logic                  wr_acc;
  logic                  win_valid;
  logic                  reg_range;
  logic                  reg_hit;
  logic                  access;
  logic [1:0]            win;
  logic [1:0]            reg_win;
  logic [BANK_REG_W-1:0] cur_bank;
  logic [BANK_REG_W-1:0] rom_bank;
  logic [24:0]           rom_last;
  logic [26:0]           rom_mask;
  logic [26:0]           rom_off;
  logic [26:0]           page;
  logic [26:0]           rom_addr;
  logic [26:0]           nxt_addr;
  logic                  nxt_ram_cs;
  logic                  nxt_sram_cs;

  assign wr_req    = cs & mreq & wr;
  // The first cycle after reset only loads prev_wr, so a write held across reset cannot commit.
  assign wr_acc    = wr_req & ~prev_wr_q & ~post_reset_q;
  assign win_valid = addr[15] ^ addr[14];
  assign reg_hit   = wr & (addr[15:13] == 3'b011);

  always_comb begin
    win       = 2'b00;
    reg_win   = 2'b00;
    reg_range = 1'b0;
    if (BANK_BITS == 13) begin
      win       = {addr[15], addr[13]};
      reg_win   = addr[12:11];
      reg_range = (addr[15:13] == 3'b011);
    end else begin
      win       = {1'b0, addr[15]};
      reg_win   = {1'b0, addr[12]};
      reg_range = (addr[15:13] == 3'b011) & ~addr[11];
    end
  end

  assign cur_bank = bank_q[win];
  assign rom_last = rom_size - 25'd1;
  assign rom_mask = {2'b00, rom_last >> BANK_BITS};
  assign page     = {{(27 - BANK_BITS){1'b0}}, addr[BANK_BITS-1:0]};
  assign access   = cs & mreq & (rd | wr) & win_valid & ~reg_hit;

`ifdef MAPPER_GEN_SRAM_EN
  logic        sram_sel;
  logic [15:0] sram_mask;
  logic [15:0] sram_page;
  logic [26:0] sram_addr;

  always_comb begin
    rom_bank           = cur_bank;
    rom_bank[SRAM_BIT] = 1'b0;
  end

  assign sram_sel    = cur_bank[SRAM_BIT] & (sram_size != 16'd0);
  assign sram_mask   = sram_size - 16'd1;
  // SRAM smaller than a bank mirrors across the whole window.
  assign sram_page   = {{(16 - BANK_BITS){1'b0}}, addr[BANK_BITS-1:0]} & sram_mask;
  assign sram_addr   = sram_base + {11'd0, sram_page};
  assign nxt_ram_cs  = access & ~sram_sel & ~wr;
  assign nxt_sram_cs = access & sram_sel & (~wr | addr[15]);
  assign nxt_addr    = sram_sel ? sram_addr : rom_addr;
`else
  logic unused_sram;

  assign rom_bank    = cur_bank;
  assign unused_sram = ^{sram_size, sram_base};
  assign nxt_ram_cs  = access & ~wr;
  assign nxt_sram_cs = 1'b0;
  assign nxt_addr    = rom_addr;
`endif

  assign rom_off  = ({{(27 - BANK_REG_W){1'b0}}, rom_bank} & rom_mask) << BANK_BITS;
  assign rom_addr = base_ram + rom_off + page;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        bank_q[i] <= '0;
      end
      prev_wr_q    <= 1'b0;
      post_reset_q <= 1'b1;
      out_addr     <= '0;
      out_ram_cs   <= 1'b0;
      out_sram_cs  <= 1'b0;
      out_rnw      <= 1'b1;
    end else begin
      prev_wr_q    <= wr_req;
      post_reset_q <= 1'b0;
      if (wr_acc && reg_range) begin
        bank_q[reg_win] <= data[BANK_REG_W-1:0];
      end
      out_addr    <= nxt_addr;
      out_ram_cs  <= nxt_ram_cs;
      out_sram_cs <= nxt_sram_cs;
      out_rnw     <= ~wr;
    end
  end

  always_comb begin
    bank_dbg = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      bank_dbg[i*BANK_REG_W +: BANK_REG_W] = bank_q[i];
    end
  end

endmodule

// File: tb/tb_mapper_ascii_gen.sv
// Directed bench for mapper_ascii_gen: one 8 KB and one 16 KB instance share the CPU bus.
// SRAM checks are compiled in with `define MAPPER_GEN_SRAM_EN.
module tb_mapper_ascii_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        mreq;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  data;
  logic [24:0] rom_size;
  logic [26:0] base_ram;
  logic [15:0] sram_size;
  logic [26:0] sram_base;

  logic [26:0] a13_addr, a14_addr;
  logic        a13_ram, a14_ram, a13_sram, a14_sram, a13_rnw, a14_rnw;
  logic [31:0] dbg13, dbg14;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mapper_ascii_gen #(.BANK_BITS(13)) dut13 (
    .clk(clk), .reset(reset), .cs(cs), .mreq(mreq), .rd(rd), .wr(wr), .addr(addr), .data(data),
    .rom_size(rom_size), .base_ram(base_ram), .sram_size(sram_size), .sram_base(sram_base),
    .out_addr(a13_addr), .out_ram_cs(a13_ram), .out_sram_cs(a13_sram), .out_rnw(a13_rnw),
    .bank_dbg(dbg13)
  );

  mapper_ascii_gen #(.BANK_BITS(14)) dut14 (
    .clk(clk), .reset(reset), .cs(cs), .mreq(mreq), .rd(rd), .wr(wr), .addr(addr), .data(data),
    .rom_size(rom_size), .base_ram(base_ram), .sram_size(sram_size), .sram_base(sram_base),
    .out_addr(a14_addr), .out_ram_cs(a14_ram), .out_sram_cs(a14_sram), .out_rnw(a14_rnw),
    .bank_dbg(dbg14)
  );

  typedef struct {
    logic        is_wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [26:0] exp_addr;
    logic        chk_addr;
    logic        exp_ram;
    logic        exp_rnw;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    cs   = 1'b0;
    mreq = 1'b0;
    rd   = 1'b0;
    wr   = 1'b0;
  endtask

  task automatic bus(input logic is_wr, input logic [15:0] a, input logic [7:0] d);
    cs   = 1'b1;
    mreq = 1'b1;
    rd   = ~is_wr;
    wr   = is_wr;
    addr = a;
    data = d;
  endtask

  // One-cycle access followed by one idle cycle, so every write is a fresh rising edge.
  task automatic pulse(input logic is_wr, input logic [15:0] a, input logic [7:0] d);
    bus(is_wr, a, d);
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h4000, 8'h00, 27'h100000, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 16'h6800, 8'h05, 27'h0,      1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h6123, 8'h00, 27'h10A123, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 16'h7000, 8'h12, 27'h0,      1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h9FFF, 8'h00, 27'h105FFF, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'hC000, 8'h00, 27'h0,      1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 16'h3FFF, 8'h00, 27'h0,      1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 16'hA000, 8'h33, 27'h0,      1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h4010, 8'h00, 27'h100010, 1'b1, 1'b1, 1'b1};

    rom_size  = 25'h20000;
    base_ram  = 27'h100000;
    sram_size = 16'h2000;
    sram_base = 27'h200000;
    addr      = 16'h0000;
    data      = 8'h00;
    idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ram_cs", {31'd0, a13_ram}, 32'd0);
    chk("reset sram_cs", {31'd0, a13_sram}, 32'd0);
    chk("reset rnw", {31'd0, a13_rnw}, 32'd1);
    chk("reset addr", {5'd0, a13_addr}, 32'd0);
    chk("reset bank_dbg", dbg13, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      bus(vecs[i].is_wr, vecs[i].a, vecs[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d ram_cs", i), {31'd0, a13_ram}, {31'd0, vecs[i].exp_ram});
      chk($sformatf("vec%0d sram_cs", i), {31'd0, a13_sram}, 32'd0);
      chk($sformatf("vec%0d rnw", i), {31'd0, a13_rnw}, {31'd0, vecs[i].exp_rnw});
      if (vecs[i].chk_addr) begin
        chk($sformatf("vec%0d addr", i), {5'd0, a13_addr}, {5'd0, vecs[i].exp_addr});
      end
      idle();
      @(negedge clk);
    end
    chk("table bank_dbg", dbg13, 32'h0012_0500);

    // Long write: data changes while wr stays high; only the first value may commit.
    bus(1'b1, 16'h7800, 8'h1F);
    @(negedge clk);
    data = 8'h0A;
    repeat (5) @(negedge clk);
    idle();
    @(negedge clk);
    chk("long write bank_dbg", dbg13, 32'h1F12_0500);
    bus(1'b0, 16'hA010, 8'h00);
    @(negedge clk);
    chk("wrap addr", {5'd0, a13_addr}, 32'h011E010);
    chk("wrap ram_cs", {31'd0, a13_ram}, 32'd1);
    cs = 1'b0;
    @(negedge clk);
    chk("cs drop ram_cs", {31'd0, a13_ram}, 32'd0);
    idle();
    @(negedge clk);

    // Register write immediately followed by a read of the same window.
    bus(1'b1, 16'h6000, 8'h03);
    @(negedge clk);
    bus(1'b0, 16'h4000, 8'h00);
    @(negedge clk);
    chk("b2b addr", {5'd0, a13_addr}, 32'h0106000);
    chk("b2b ram_cs", {31'd0, a13_ram}, 32'd1);
    idle();
    @(negedge clk);

    // Reset while a register write is held, then release with wr still high.
    bus(1'b1, 16'h6000, 8'h07);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid-reset rnw", {31'd0, a13_rnw}, 32'd1);
    chk("mid-reset bank_dbg", dbg13, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post-reset bank13", dbg13, 32'd0);
    chk("post-reset bank14", dbg14, 32'd0);
    idle();
    @(negedge clk);

    // 16 KB decode: 0x7000 hits window 1, 0x6800 (addr[11]=1) is ignored.
    pulse(1'b1, 16'h7000, 8'h03);
    pulse(1'b1, 16'h6800, 8'h09);
    chk("16k bank_dbg", dbg14, 32'h0000_0300);
    chk("8k shadow bank_dbg", dbg13, 32'h0003_0900);
    bus(1'b0, 16'h8004, 8'h00);
    @(negedge clk);
    chk("16k addr", {5'd0, a14_addr}, 32'h010C004);
    chk("16k ram_cs", {31'd0, a14_ram}, 32'd1);
    chk("16k sram_cs", {31'd0, a14_sram}, 32'd0);
    chk("16k rnw", {31'd0, a14_rnw}, 32'd1);
    idle();
    @(negedge clk);

`ifdef MAPPER_GEN_SRAM_EN
    pulse(1'b1, 16'h7000, 8'h80);
    bus(1'b1, 16'h8005, 8'h5A);
    @(negedge clk);
    chk("sram wr sram_cs", {31'd0, a13_sram}, 32'd1);
    chk("sram wr ram_cs", {31'd0, a13_ram}, 32'd0);
    chk("sram wr rnw", {31'd0, a13_rnw}, 32'd0);
    chk("sram wr addr", {5'd0, a13_addr}, 32'h0200005);
    idle();
    @(negedge clk);
    pulse(1'b1, 16'h6000, 8'h80);
    bus(1'b1, 16'h4005, 8'h5A);
    @(negedge clk);
    chk("sram low wr sram_cs", {31'd0, a13_sram}, 32'd0);
    idle();
    @(negedge clk);
    bus(1'b0, 16'h5FF5, 8'h00);
    @(negedge clk);
    chk("sram low rd sram_cs", {31'd0, a13_sram}, 32'd1);
    chk("sram low rd addr", {5'd0, a13_addr}, 32'h0201FF5);
    idle();
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mapper_ascii_gen.md
Name: mapper_ascii_gen

Overview:
- Parametrised ASCII-family MegaROM mapper; a single RTL replaces the separate 8 KB and 16 KB ASCII mappers.
- Decodes CPU bank-register writes and holds per-window bank registers.
- Translates CPU addresses 0x4000-0xBFFF into 27-bit memory addresses with ram_cs/sram_cs/rnw, matching the mapper_out convention.
- Sits between the slot decoder and the SDRAM/BRAM arbiter.

Parameters:
- BANK_BITS, 13, log2 of bank size; legal values are 13 (8 KB, 4 windows) and 14 (16 KB, 2 windows).
- BANK_REG_W, 8, width of each bank register.
- SRAM_BIT, 7, bank-register bit that selects SRAM instead of ROM; used only with MAPPER_GEN_SRAM_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cs  in  1  slot/subslot select for this cartridge
- mreq  in  1  CPU memory request
- rd  in  1  CPU read strobe
- wr  in  1  CPU write strobe
- addr  in  16  CPU address
- data  in  8  CPU write data
- rom_size  in  25  ROM image size in bytes (power of two, at least one bank)
- base_ram  in  27  ROM base in memory
- sram_size  in  16  SRAM size in bytes (0 means none)
- sram_base  in  27  SRAM base in memory
- out_addr  out  27  translated address
- out_ram_cs  out  1  ROM access valid
- out_sram_cs  out  1  SRAM access valid
- out_rnw  out  1  1 = read, 0 = write
- bank_dbg  out  4*BANK_REG_W  bank registers concatenated, window 0 in the LSBs (windows beyond NUM_WIN read 0)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Geometry: NUM_WIN = 0x8000 >> BANK_BITS. Window w = (addr - 0x4000) >> BANK_BITS, valid only for 0x4000 <= addr <= 0xBFFF.
- Write acceptance: wr_acc = cs & mreq & wr & ~prev_wr, where prev_wr is the registered value of (cs & mreq & wr). This gives exactly one commit per CPU write, however many clk cycles the write spans.
- Register decode, BANK_BITS=13: addr in 0x6000-0x7FFF; window = addr[12:11].
- Register decode, BANK_BITS=14: addr in 0x6000-0x7FFF with addr[11]=0; window = addr[12]. Writes with addr[11]=1 are ignored.
- On wr_acc with a decoded register address: bank[window] <= data[BANK_REG_W-1:0] on the next clk edge.
- Register writes never reach memory: out_ram_cs=0 and out_sram_cs=0 for that access.
- ROM translation: out_addr = base_ram + ((bank[w] & bank_mask) << BANK_BITS) + addr[BANK_BITS-1:0], where bank_mask = (rom_size-1) >> BANK_BITS. Out-of-range bank numbers therefore wrap.
- Address arithmetic is 27 bits; carry out of the adder is discarded.
- ROM access: out_ram_cs = cs & mreq & (rd|wr) & window valid & ~register hit & ~SRAM selected.
- ROM writes: out_rnw = ~wr, but out_ram_cs is forced to 0 on writes. ROM is read-only.
- Output registers: out_* are registered, so there is 1 clk latency from input to output. Outputs go low 1 clk after cs or mreq drops.
- Simultaneous events: a register write and a read of the same window in consecutive cycles. The read uses the new bank value once the register has updated (register update first, output translation the next cycle).
- Reset values: all bank registers 0; out_addr=0; out_ram_cs=0; out_sram_cs=0; out_rnw=1; prev_wr=0.
- Reset mid-write: the write is aborted and registers stay at 0. A wr still held after reset deasserts does not commit, because prev_wr is loaded on the first cycle after reset and the write then has no rising edge.
- Invalid BANK_BITS: elaboration must fail via $error.

Optional Feature:
- Macro: MAPPER_GEN_SRAM_EN.
- Defined, SRAM select: bank[w][SRAM_BIT]=1 with sram_size != 0 selects SRAM.
  - out_addr = sram_base + (addr[BANK_BITS-1:0] & (sram_size-1)); the SRAM mirrors across the window.
  - Reads are allowed in any window.
  - Writes are allowed only when addr[15]=1 (0x8000-0xBFFF). Writes elsewhere are suppressed with out_sram_cs=0.
  - The SRAM bit is excluded from ROM bank masking.
- Not defined: SRAM_BIT is an ordinary bank bit, out_sram_cs is tied to 0, and sram_size and sram_base are ignored.

Test Plan:
- Reset and first read, BANK_BITS=13, rom_size=0x20000, base_ram=0x100000: reset, then read 0x4000 -> out_addr=0x100000, out_ram_cs=1 one clk later, bank_dbg=0.
- 8 KB bank switching: write 0x05 to 0x6800, then read 0x6123 -> out_addr=0x100000+0xA000+0x0123=0x10A123.
- Bank wrap and long write: write 0x1F to 0x7800 with wr held 6 clk, then read 0xA010. The register commits once, and the wrapped bank (0x1F & 0xF = 0xF) gives out_addr=0x100000+0x1E000+0x0010=0x11E010.
- 16 KB decode, BANK_BITS=14: write 0x03 to 0x7000 -> window 1 bank=3. Write 0x09 to 0x6800 -> ignored. Read 0x8004 -> base_ram+0xC004.
- SRAM, with MAPPER_GEN_SRAM_EN, sram_size=0x2000, sram_base=0x200000: write 0x80 to 0x7000, then write to 0x8005 -> out_sram_cs=1, out_rnw=0, out_addr=0x200005. Write 0x80 to 0x6000, then write to 0x4005 -> out_sram_cs=0.
- Reset mid-write: assert reset while wr to 0x6000 with data 0x07 is held. After release, with wr still high, bank[0] stays 0.
